// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI peripheral endpoint: default frame width,
// mode 0 clock constants and the frame FSM state encoding.
package spi_peripheral_pkg;

    // Frame width shared with the CPU-side SPI master.
    localparam int W_CPU = 32;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam bit MODE0_CPOL = 1'b0;
    localparam bit MODE0_CPHA = 1'b0;

    // Idle level of the serial clock, also the synchroniser reset value.
    localparam bit SCLK_IDLE = MODE0_CPOL;

    // Mode 0 samples on the leading (rising) edge and shifts on the trailing edge.
    localparam bit SAMPLE_ON_RISE = (MODE0_CPOL == MODE0_CPHA);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised output.
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Shift the asynchronous input through the synchroniser chain and keep
    // the previous synchronised value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign dout = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode 0 peripheral endpoint, MSB first, fully oversampled on clk.
// One tx buffer word feeds miso; completed mosi words appear on rx_data.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int W_DATA      = W_CPU,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_overrun,
    input  logic              rx_ack,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(W_DATA);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W_DATA - 1);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic ss_s, ss_rise_s, ss_fall_s;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_clk),
        .dout(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss_n),
        .dout(ss_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Mode 0 samples on the rising edge, shifts on the falling edge.
    logic sample_edge_s, shift_edge_s;
    assign sample_edge_s = SAMPLE_ON_RISE ? sclk_rise_s : sclk_fall_s;
    assign shift_edge_s  = SAMPLE_ON_RISE ? sclk_fall_s : sclk_rise_s;

    spi_state_t        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [W_DATA-1:0] rx_shift_r;
    logic [W_DATA-1:0] tx_shift_r;
    logic [W_DATA-1:0] tx_buf_r;
    logic              tx_full_r;
    logic              rx_pending_r;
    logic              reload_r;
    logic              starve_r;

    assign miso     = (state_r == ST_ACTIVE) ? tx_shift_r[W_DATA-1] : 1'b0;
    assign miso_oe  = ~ss_s;
    assign tx_ready = ~tx_full_r;

    // Frame FSM: tx buffer, shift registers, bit counter and status pulses.
    // A word reloaded from an empty buffer at a frame boundary only reports
    // an underrun once the master actually clocks the next frame (starve_r),
    // so the trailing clock fall of the final frame is silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            rx_shift_r   <= {W_DATA{1'b0}};
            tx_shift_r   <= {W_DATA{1'b0}};
            tx_buf_r     <= {W_DATA{1'b0}};
            tx_full_r    <= 1'b0;
            rx_data      <= {W_DATA{1'b0}};
            rx_valid     <= 1'b0;
            rx_pending_r <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;
            reload_r     <= 1'b0;
            starve_r     <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            if (rx_ack) begin
                rx_pending_r <= 1'b0;
                rx_overrun   <= 1'b0;
            end
            if (tx_load && !tx_full_r) begin
                tx_buf_r  <= tx_data;
                tx_full_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        state_r   <= ST_ACTIVE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        reload_r  <= 1'b0;
                        starve_r  <= 1'b0;
                        if (tx_full_r) begin
                            tx_shift_r <= tx_buf_r;
                            tx_full_r  <= 1'b0;
                        end else begin
                            tx_shift_r  <= {W_DATA{1'b0}};
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise_s) begin
                        state_r    <= ST_IDLE;
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        rx_shift_r <= {W_DATA{1'b0}};
                        reload_r   <= 1'b0;
                        starve_r   <= 1'b0;
                        if (bit_cnt_r != {CNT_W{1'b0}}) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sample_edge_s) begin
                        rx_shift_r <= {rx_shift_r[W_DATA-2:0], mosi_s};
                        if (starve_r) begin
                            tx_underrun <= 1'b1;
                            starve_r    <= 1'b0;
                        end
                        if (bit_cnt_r == LAST_BIT) begin
                            rx_data      <= {rx_shift_r[W_DATA-2:0], mosi_s};
                            rx_valid     <= 1'b1;
                            bit_cnt_r    <= {CNT_W{1'b0}};
                            rx_pending_r <= 1'b1;
                            reload_r     <= 1'b1;
                            if (rx_pending_r && !rx_ack) begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (shift_edge_s) begin
                        if (reload_r) begin
                            reload_r <= 1'b0;
                            if (tx_full_r) begin
                                tx_shift_r <= tx_buf_r;
                                tx_full_r  <= 1'b0;
                            end else begin
                                tx_shift_r <= {W_DATA{1'b0}};
                                starve_r   <= 1'b1;
                            end
                        end else if (bit_cnt_r != {CNT_W{1'b0}}) begin
                            tx_shift_r <= tx_shift_r << 1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: a behavioural SPI master drives
// frames while a word-level model tracks tx buffer, rx status and pulse counts.
module tb_spi_peripheral;

    localparam int W    = 32;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst, spi_clk, ss_n, mosi, miso, miso_oe;
    logic         tx_load, tx_ready, rx_valid, rx_overrun, rx_ack, tx_underrun, frame_err;
    logic [W-1:0] tx_data, rx_data;

    int checks = 0;
    int errors = 0;

    // Pulse monitors
    int           rxv_cnt = 0;
    int           und_cnt = 0;
    int           ferr_cnt = 0;
    logic [W-1:0] rx_log[$];

    // Word-level reference model
    bit           m_full = 1'b0;
    logic [W-1:0] m_buf  = '0;
    logic [W-1:0] m_rx   = '0;
    bit           m_pend = 1'b0;
    bit           m_ovr  = 1'b0;
    int           m_rxv  = 0;
    int           m_und  = 0;
    int           m_ferr = 0;

    logic [W-1:0] cap;
    logic [W-1:0] exp_a, exp_b, word;

    spi_peripheral #(.W_DATA(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_overrun(rx_overrun), .rx_ack(rx_ack), .tx_underrun(tx_underrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count status pulses away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_underrun) und_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            mosi = w[W-1-i];
            tick(HALF);
            cap = {cap[W-2:0], miso};
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic select_dev();
        ss_n = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect_dev();
        tick(HALF);
        ss_n = 1'b1;
        tick(3 * HALF);
    endtask

    // Frame start: the buffered word is sent, or zeros with an underrun.
    task automatic model_start(output logic [W-1:0] e);
        if (m_full) begin
            e = m_buf;
            m_full = 1'b0;
        end else begin
            e = '0;
            m_und++;
        end
    endtask

    // Word boundary inside a selected frame: buffer is consumed; an empty
    // buffer only counts as underrun if another frame is actually clocked.
    task automatic model_boundary(input bit continues, output logic [W-1:0] e);
        if (m_full) begin
            e = m_buf;
            m_full = 1'b0;
        end else begin
            e = '0;
            if (continues) m_und++;
        end
    endtask

    task automatic model_rx(input logic [W-1:0] w);
        m_rx = w;
        if (m_pend) m_ovr = 1'b1;
        m_pend = 1'b1;
        m_rxv++;
    endtask

    task automatic load_word(input logic [W-1:0] w);
        int t;
        t = 0;
        while (!tx_ready && t < 100) begin
            tick(1);
            t++;
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data = w;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        m_buf  = w;
        m_full = 1'b1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rx_data"}, rx_data, m_rx);
        check({tag, "_overrun"}, {31'd0, rx_overrun}, {31'd0, m_ovr});
        check({tag, "_rxv_cnt"}, rxv_cnt, m_rxv);
        check({tag, "_und_cnt"}, und_cnt, m_und);
        check({tag, "_ferr_cnt"}, ferr_cnt, m_ferr);
    endtask

    task automatic full_frame(input logic [W-1:0] w, input string tag);
        logic [W-1:0] e, dummy;
        model_start(e);
        select_dev();
        cap = '0;
        send_bits(w, 0, W);
        model_boundary(1'b0, dummy);
        deselect_dev();
        model_rx(w);
        check({tag, "_miso"}, cap, e);
        check_status(tag);
    endtask

    initial begin
        rst = 1'b1; spi_clk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
        tick(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Basic frame with preloaded tx word
        load_word(32'hA5A5_0F0F);
        check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
        full_frame(32'h1234_5678, "basic");
        do_ack();

        // Back-to-back frames with ss_n held low
        load_word(32'h1111_1111);
        model_start(exp_a);
        select_dev();
        check("miso_oe_sel", {31'd0, miso_oe}, 32'd1);
        cap = '0;
        send_bits(32'hDEAD_BEEF, 0, 16);
        load_word(32'h2222_2222);
        send_bits(32'hDEAD_BEEF, 16, 16);
        check("b2b_miso0", cap, exp_a);
        model_boundary(1'b1, exp_b);
        cap = '0;
        send_bits(32'h0000_0001, 0, W);
        check("b2b_miso1", cap, exp_b);
        model_boundary(1'b0, exp_a);
        deselect_dev();
        model_rx(32'hDEAD_BEEF);
        model_rx(32'h0000_0001);
        check("b2b_order0", rx_log[rx_log.size()-2], 32'hDEAD_BEEF);
        check("b2b_order1", rx_log[rx_log.size()-1], 32'h0000_0001);
        check_status("b2b");
        do_ack();

        // Empty tx buffer, then overrun on a second unacknowledged frame
        full_frame(32'h5555_AAAA, "underrun");
        full_frame(32'h0F1E_2D3C, "overrun");
        do_ack();
        check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);

        // Deselect after 13 bits
        model_start(exp_a);
        select_dev();
        send_bits(32'hFFFF_FFFF, 0, 13);
        deselect_dev();
        m_ferr++;
        check_status("frame_err");
        load_word(32'h3C3C_C3C3);
        full_frame(32'hCAFE_F00D, "after_ferr");
        do_ack();

        // Reset in the middle of a frame
        load_word(32'h7777_0000);
        model_start(exp_a);
        select_dev();
        send_bits(32'h8888_9999, 0, 20);
        rst = 1'b1;
        tick(2);
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_data", rx_data, 32'd0);
        ss_n = 1'b1;
        spi_clk = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(4);
        m_full = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_rx = '0;
        check_status("mid_rst");
        full_frame(32'h0BAD_C0DE, "after_rst");

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            word = $urandom;
            if ($urandom_range(0, 1) == 1) load_word($urandom);
            if ($urandom_range(0, 1) == 1) do_ack();
            full_frame(word, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI peripheral (slave) endpoint: the far end of the CPU-side SPI master. Receives words on mosi and returns words on miso, mode 0 (CPOL=0, CPHA=0), MSB first.
- Runs on the system clock `clk`. It oversamples the master's `spi_clk`, `mosi` and `ss_n`; it never clocks logic on `spi_clk`.
- Sits in the testbench/SoC as the external device that feeds the master's MISO receiver and consumes its MOSI transmitter.

Parameters:
- W_DATA, 32, frame width in bits; matches `W_CPU`.
- SYNC_STAGES, 2, synchroniser depth for `spi_clk`, `mosi` and `ss_n`; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spi_clk  in  1  serial clock from the master.
- ss_n  in  1  active-low select from the master.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  miso drive enable; equals the synchronised `!ss_n`.
- tx_data  in  W_DATA  next word to return to the master.
- tx_load  in  1  writes `tx_data` into the tx buffer; honoured only while `tx_ready`=1.
- tx_ready  out  1  tx buffer empty.
- rx_data  out  W_DATA  last complete received word.
- rx_valid  out  1  one-cycle pulse when `rx_data` updates.
- rx_overrun  out  1  sticky; set when `rx_valid` fires while `rx_pending`=1.
- rx_ack  in  1  clears `rx_pending` and `rx_overrun`.
- tx_underrun  out  1  one-cycle pulse when a frame starts with the tx buffer empty.
- frame_err  out  1  one-cycle pulse when `ss_n` rises mid-frame.

Behaviour:
- Reset state (async): miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, frame_err=0, bit_cnt=0, shift registers=0, FSM=IDLE. Synchroniser flops reset to spi_clk=0, ss_n=1, mosi=0.
- Edge detection: `sclk_rise` and `sclk_fall` come from the last synchroniser stage versus its previous value. Sampling latency is SYNC_STAGES+1 clk cycles. The master must keep `spi_clk` high and low for at least SYNC_STAGES+2 clk cycles each.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE when synchronised `ss_n` falls.
    - tx_shift <= tx_buf if the buffer is full, else 0 with `tx_underrun` pulsed.
    - tx buffer marked empty (tx_ready=1 on the next cycle).
    - bit_cnt <= 0.
  - In ACTIVE, on `sclk_rise`: rx_shift <= {rx_shift[W_DATA-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches W_DATA on that rise:
    - rx_data <= the completed word, rx_valid pulses for 1 cycle, bit_cnt <= 0.
    - If rx_pending was already 1, rx_overrun <= 1.
    - rx_pending <= 1.
    - A reload flag is set for the next fall.
  - In ACTIVE, on `sclk_fall`:
    - If the reload flag is set: tx_shift reloads from tx_buf (or 0 with `tx_underrun`), the buffer empties, and the flag clears.
    - Otherwise tx_shift <= tx_shift << 1.
    - This gives back-to-back frames without deselecting.
  - A fall with bit_cnt=0 and no reload flag (first fall of a frame) is ignored for shifting, so the MSB is presented before the first rise.
  - ACTIVE -> IDLE when `ss_n` rises.
    - If bit_cnt != 0: frame_err pulses and the partial rx word is discarded (rx_data unchanged).
    - A consumed tx word is not restored.
- miso = tx_shift[W_DATA-1] while ACTIVE, else 0.
- tx_ready = !tx_full. tx_load while tx_ready=0 is ignored (no overwrite).
- Same-cycle tx_load and frame-start consume: the load is refused that cycle, because tx_ready is still 0.
- Same-cycle rx_ack and rx_valid: the new word wins; rx_pending=1 and rx_overrun is cleared.
- rst asserted mid-frame: all state returns to reset values immediately; a frame in progress is lost with no pulses.

Decomposition:
- Shared package: MODE0 constants, the IDLE/ACTIVE state encoding, and the default width tied to `W_CPU`.
- One sub-module: `spi_sync_edge`, a SYNC_STAGES synchroniser plus rise/fall detector, instantiated for `spi_clk` and `ss_n` and as a plain synchroniser for `mosi`.

Test Plan:
- Preload tx 0xA5A5_0F0F; master sends 0x1234_5678 with 32 clocks, 8 clk per half-period -> rx_data=0x12345678, rx_valid high exactly 1 cycle; master captures 0xA5A50F0F on miso.
- Two back-to-back frames (0xDEADBEEF, 0x00000001), ss_n held low, tx_load 0x11111111 then 0x22222222 between frames -> two rx_valid pulses in order; miso returns 0x11111111 then 0x22222222; no underrun.
- Frame with tx buffer empty -> tx_underrun pulses at frame start; miso stays 0 for all 32 bits; rx still completes.
- Second frame without rx_ack -> rx_overrun=1 sticky; rx_data=second word; rx_ack clears it.
- ss_n rises after 13 bits -> frame_err pulses; no rx_valid; rx_data unchanged; a following full frame of 0xCAFEF00D is received correctly.
- rst pulsed after 20 bits -> all outputs at reset values; no rx_valid; a subsequent frame of 0x0BADC0DE is received correctly.
